reversi_control: RTL and testbench



---
 rtl/reversi_control_if.sv | 49 ++++
 rtl/reversi_control.sv | 207 ++++++++++++++++++++
 tb/tb_reversi_control.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reversi_control_if.sv
// -----------------------------------------------------------------------------
// reversi_control_if
// Purpose : enable/go handshake bundle between the reversi game-flow
//           controller (master) and the drawing/board datapath (slave).
// Signals :
//   go, validMove, hasTurn          datapath -> controller (done + results)
//   writeEn                         controller -> VGA plot enable
//   *En, determineOpponent/Current  controller -> datapath operation enables
// -----------------------------------------------------------------------------
interface reversi_control_if;
  logic go;
  logic validMove;
  logic hasTurn;
  logic writeEn;
  logic drawBoardEn;
  logic drawInitialPiecesEn;
  logic moveRightEn;
  logic moveLeftEn;
  logic moveUpEn;
  logic moveDownEn;
  logic moveHighlightEn;
  logic checkIfValidMoveEn;
  logic placeEn;
  logic flipEn;
  logic scoreManagerEn;
  logic determineHasTurnEn;
  logic determineOpponent;
  logic determineCurrent;
  logic TurnManagerEn;
  logic removeHighlightEn;

  modport master (
    input  go, validMove, hasTurn,
    output writeEn, drawBoardEn, drawInitialPiecesEn,
           moveRightEn, moveLeftEn, moveUpEn, moveDownEn, moveHighlightEn,
           checkIfValidMoveEn, placeEn, flipEn, scoreManagerEn,
           determineHasTurnEn, determineOpponent, determineCurrent,
           TurnManagerEn, removeHighlightEn
  );

  modport slave (
    output go, validMove, hasTurn,
    input  writeEn, drawBoardEn, drawInitialPiecesEn,
           moveRightEn, moveLeftEn, moveUpEn, moveDownEn, moveHighlightEn,
           checkIfValidMoveEn, placeEn, flipEn, scoreManagerEn,
           determineHasTurnEn, determineOpponent, determineCurrent,
           TurnManagerEn, removeHighlightEn
  );
endinterface

// File: rtl/reversi_control.sv
// -----------------------------------------------------------------------------
// reversi_control
// Purpose : game-flow controller for the reversi VGA design. Decodes key
//           presses and sequences datapath operations one at a time over the
//           enable/go handshake; branches on validMove / hasTurn.
// Ports   :
//   clk, resetn        clock, asynchronous active-low reset
//   key_*              active-high key levels (already synchronous to clk)
//   dp                 handshake bundle (master side): go/validMove/hasTurn in,
//                      writeEn + operation enables out
//   game_over          high while in GAME_OVER
//   error              watchdog trip flag
// Parameter:
//   GO_TIMEOUT         handshake cycles allowed before the watchdog trips
// Build option:
//   CTRL_WATCHDOG_EN   defined   -> go watchdog present, ERROR reachable
//                      undefined -> no watchdog, error tied low
// -----------------------------------------------------------------------------
module reversi_control #(
  parameter int unsigned GO_TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               key_enter,
  input  logic               key_right,
  input  logic               key_left,
  input  logic               key_up,
  input  logic               key_down,
  reversi_control_if.master  dp,
  output logic               game_over,
  output logic               error
);

  typedef enum logic [3:0] {
    S_DRAW_BOARD, S_INIT_PIECES, S_HIGHLIGHT, S_WAIT_KEY,
    S_MOVE,       S_CHECK,       S_PLACE,     S_FLIP,
    S_SCORE,      S_TURN,        S_DET_CUR,   S_DET_OPP,
    S_TURN2,      S_REMOVE_HL,   S_GAME_OVER, S_ERROR
  } state_t;

  // Bit positions inside the registered output vector
  localparam int O_DRAW = 0,  O_INIT = 1,  O_MR = 2,    O_ML = 3;
  localparam int O_MU = 4,    O_MD = 5,    O_HL = 6,    O_CHK = 7;
  localparam int O_PLACE = 8, O_FLIP = 9,  O_SCORE = 10, O_DHT = 11;
  localparam int O_DOPP = 12, O_DCUR = 13, O_TURN = 14, O_RHL = 15;
  localparam int O_WE = 16,   O_GOVER = 17, O_ERR = 18;

  state_t      r_state, w_state_next;
  logic        r_gap, w_gap_next;
  logic [1:0]  r_dir, w_dir_next;     // 0 right, 1 left, 2 up, 3 down
  logic [4:0]  r_key_prev;
  logic [4:0]  w_keys, w_press;       // bit 0 enter ... bit 4 down
  logic [18:0] r_out;
  logic        w_is_hs, w_hs_done;

  assign w_keys  = {key_down, key_up, key_left, key_right, key_enter};
  assign w_press = w_keys & ~r_key_prev;

  assign w_is_hs = r_state inside {S_DRAW_BOARD, S_INIT_PIECES, S_HIGHLIGHT,
                                   S_CHECK, S_PLACE, S_FLIP, S_SCORE, S_TURN,
                                   S_DET_CUR, S_DET_OPP, S_TURN2, S_REMOVE_HL};
  // go only counts once the enable has actually been presented (gap low)
  assign w_hs_done = w_is_hs && !r_gap && dp.go;

`ifdef CTRL_WATCHDOG_EN
  logic [19:0] r_wd_cnt;
  logic [19:0] w_wd_inc;
  assign w_wd_inc = r_wd_cnt + 20'd1;
`endif

  // Moore decode of {state, gap}; applied to the next-state values so the
  // registered outputs line up with the state they describe.
  function automatic logic [18:0] f_decode(state_t s, logic gap, logic [1:0] dir);
    logic [18:0] v;
    v = '0;
    if (!gap) begin
      case (s)
        S_DRAW_BOARD:  begin v[O_DRAW] = 1'b1;  v[O_WE] = 1'b1; end
        S_INIT_PIECES: begin v[O_INIT] = 1'b1;  v[O_WE] = 1'b1; end
        S_HIGHLIGHT:   begin v[O_HL] = 1'b1;    v[O_WE] = 1'b1; end
        S_MOVE: begin
          case (dir)
            2'd0:    v[O_MR] = 1'b1;
            2'd1:    v[O_ML] = 1'b1;
            2'd2:    v[O_MU] = 1'b1;
            default: v[O_MD] = 1'b1;
          endcase
        end
        S_CHECK:       v[O_CHK] = 1'b1;
        S_PLACE:       begin v[O_PLACE] = 1'b1; v[O_WE] = 1'b1; end
        S_FLIP:        begin v[O_FLIP] = 1'b1;  v[O_WE] = 1'b1; end
        S_SCORE:       v[O_SCORE] = 1'b1;
        S_TURN,
        S_TURN2:       v[O_TURN] = 1'b1;
        S_DET_CUR:     begin v[O_DHT] = 1'b1; v[O_DCUR] = 1'b1; end
        S_DET_OPP:     begin v[O_DHT] = 1'b1; v[O_DOPP] = 1'b1; end
        S_REMOVE_HL:   begin v[O_RHL] = 1'b1; v[O_WE] = 1'b1; end
        default:       ;
      endcase
    end
    // status flags follow the state regardless of the gap cycle
    if (s == S_GAME_OVER) v[O_GOVER] = 1'b1;
    if (s == S_ERROR)     v[O_ERR]   = 1'b1;
    return v;
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_gap_next   = 1'b0;
    w_dir_next   = r_dir;
    case (r_state)
      S_DRAW_BOARD:  if (w_hs_done) begin w_state_next = S_INIT_PIECES; w_gap_next = 1'b1; end
      S_INIT_PIECES: if (w_hs_done) begin w_state_next = S_HIGHLIGHT;   w_gap_next = 1'b1; end
      S_HIGHLIGHT:   if (w_hs_done) begin w_state_next = S_WAIT_KEY;    w_gap_next = 1'b1; end
      S_WAIT_KEY: begin
        if (w_press[0])      w_state_next = S_CHECK;
        else if (w_press[1]) begin w_state_next = S_MOVE; w_dir_next = 2'd0; end
        else if (w_press[2]) begin w_state_next = S_MOVE; w_dir_next = 2'd1; end
        else if (w_press[3]) begin w_state_next = S_MOVE; w_dir_next = 2'd2; end
        else if (w_press[4]) begin w_state_next = S_MOVE; w_dir_next = 2'd3; end
      end
      // single-cycle cursor step; the gap gives the datapath a settle cycle
      S_MOVE:        begin w_state_next = S_HIGHLIGHT; w_gap_next = 1'b1; end
      S_CHECK: if (w_hs_done) begin
        w_state_next = dp.validMove ? S_PLACE : S_WAIT_KEY;
        w_gap_next   = 1'b1;
      end
      S_PLACE:       if (w_hs_done) begin w_state_next = S_FLIP;    w_gap_next = 1'b1; end
      S_FLIP:        if (w_hs_done) begin w_state_next = S_SCORE;   w_gap_next = 1'b1; end
      S_SCORE:       if (w_hs_done) begin w_state_next = S_TURN;    w_gap_next = 1'b1; end
      S_TURN:        if (w_hs_done) begin w_state_next = S_DET_CUR; w_gap_next = 1'b1; end
      S_DET_CUR: if (w_hs_done) begin
        w_state_next = dp.hasTurn ? S_HIGHLIGHT : S_DET_OPP;
        w_gap_next   = 1'b1;
      end
      S_DET_OPP: if (w_hs_done) begin
        w_state_next = dp.hasTurn ? S_TURN2 : S_REMOVE_HL;
        w_gap_next   = 1'b1;
      end
      // hands the turn back to the player who just moved
      S_TURN2:       if (w_hs_done) begin w_state_next = S_HIGHLIGHT;  w_gap_next = 1'b1; end
      S_REMOVE_HL:   if (w_hs_done) begin w_state_next = S_GAME_OVER;  w_gap_next = 1'b1; end
      S_GAME_OVER:   if (w_press[0]) begin w_state_next = S_DRAW_BOARD; w_gap_next = 1'b1; end
      default:       w_state_next = r_state;   // S_ERROR: held until reset
    endcase
`ifdef CTRL_WATCHDOG_EN
    if (w_is_hs && !r_gap && !w_hs_done && (w_wd_inc == 20'(GO_TIMEOUT))) begin
      w_state_next = S_ERROR;
      w_gap_next   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_DRAW_BOARD;
      r_gap      <= 1'b1;
      r_dir      <= 2'd0;
      r_key_prev <= '0;
      r_out      <= '0;
`ifdef CTRL_WATCHDOG_EN
      r_wd_cnt   <= '0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_gap      <= w_gap_next;
      r_dir      <= w_dir_next;
      r_key_prev <= w_keys;
      r_out      <= f_decode(w_state_next, w_gap_next, w_dir_next);
`ifdef CTRL_WATCHDOG_EN
      if (w_state_next != r_state)
        r_wd_cnt <= '0;
      else if (w_is_hs && !r_gap)
        r_wd_cnt <= w_wd_inc;
`endif
    end
  end

  assign dp.drawBoardEn         = r_out[O_DRAW];
  assign dp.drawInitialPiecesEn = r_out[O_INIT];
  assign dp.moveRightEn         = r_out[O_MR];
  assign dp.moveLeftEn          = r_out[O_ML];
  assign dp.moveUpEn            = r_out[O_MU];
  assign dp.moveDownEn          = r_out[O_MD];
  assign dp.moveHighlightEn     = r_out[O_HL];
  assign dp.checkIfValidMoveEn  = r_out[O_CHK];
  assign dp.placeEn             = r_out[O_PLACE];
  assign dp.flipEn              = r_out[O_FLIP];
  assign dp.scoreManagerEn      = r_out[O_SCORE];
  assign dp.determineHasTurnEn  = r_out[O_DHT];
  assign dp.determineOpponent   = r_out[O_DOPP];
  assign dp.determineCurrent    = r_out[O_DCUR];
  assign dp.TurnManagerEn       = r_out[O_TURN];
  assign dp.removeHighlightEn   = r_out[O_RHL];
  assign dp.writeEn             = r_out[O_WE];
  assign game_over              = r_out[O_GOVER];

`ifdef CTRL_WATCHDOG_EN
  assign error = r_out[O_ERR];
`else
  assign error = 1'b0;
  // ERROR is unreachable here, so its flag bit and the timeout are unused
  logic w_unused_ok;
  assign w_unused_ok = r_out[O_ERR] ^ (GO_TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_reversi_control.sv
// -----------------------------------------------------------------------------
// tb_reversi_control
// Scoreboard bench for reversi_control. The stimulus process pushes the
// expected enable pulses ({writeEn, 16 enables}, pulse length) into a queue;
// a monitor pops one entry every time the DUT finishes an enable pulse. A
// small responder plays the datapath: it returns go after an enable has been
// up for two cycles and drives hasTurn from per-test flags.
// -----------------------------------------------------------------------------
module tb_reversi_control;
  localparam int unsigned TO = 50;

  // enable vector bit order: {WE, RHL, TURN, DCUR, DOPP, DHT, SCORE, FLIP,
  //                           PLACE, CHK, HL, MD, MU, ML, MR, INIT, DRAW}
  localparam logic [16:0] WE      = 17'h10000;
  localparam logic [16:0] E_DRAW  = WE | 17'h00001;
  localparam logic [16:0] E_INIT  = WE | 17'h00002;
  localparam logic [16:0] E_MR    = 17'h00004;
  localparam logic [16:0] E_ML    = 17'h00008;
  localparam logic [16:0] E_MU    = 17'h00010;
  localparam logic [16:0] E_MD    = 17'h00020;
  localparam logic [16:0] E_HL    = WE | 17'h00040;
  localparam logic [16:0] E_CHK   = 17'h00080;
  localparam logic [16:0] E_PLACE = WE | 17'h00100;
  localparam logic [16:0] E_FLIP  = WE | 17'h00200;
  localparam logic [16:0] E_SCORE = 17'h00400;
  localparam logic [16:0] E_DCUR  = 17'h00800 | 17'h02000;
  localparam logic [16:0] E_DOPP  = 17'h00800 | 17'h01000;
  localparam logic [16:0] E_TURN  = 17'h04000;
  localparam logic [16:0] E_RHL   = WE | 17'h08000;

  localparam logic [4:0] K_ENTER = 5'b00001, K_RIGHT = 5'b00010, K_LEFT = 5'b00100;
  localparam logic [4:0] K_UP    = 5'b01000, K_DOWN  = 5'b10000;

  typedef struct {
    logic [16:0] vec;
    int          len;
  } ev_t;

  logic        clk;
  logic        resetn;
  logic [4:0]  keys;
  logic        game_over, error;
  logic        has_cur, has_opp, stray_go, hold_go;
  logic [16:0] en_vec;
  logic        hs_en;
  ev_t         exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;

  reversi_control_if dp();

  reversi_control #(.GO_TIMEOUT(TO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .key_enter (keys[0]),
    .key_right (keys[1]),
    .key_left  (keys[2]),
    .key_up    (keys[3]),
    .key_down  (keys[4]),
    .dp        (dp),
    .game_over (game_over),
    .error     (error)
  );

  assign en_vec = {dp.writeEn, dp.removeHighlightEn, dp.TurnManagerEn,
                   dp.determineCurrent, dp.determineOpponent, dp.determineHasTurnEn,
                   dp.scoreManagerEn, dp.flipEn, dp.placeEn, dp.checkIfValidMoveEn,
                   dp.moveHighlightEn, dp.moveDownEn, dp.moveUpEn, dp.moveLeftEn,
                   dp.moveRightEn, dp.drawInitialPiecesEn, dp.drawBoardEn};
  assign hs_en = |(en_vec & 17'h0FFC3);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath model: go after two enable cycles, hasTurn chosen per query
  initial begin
    int age;
    age = 0;
    dp.go = 1'b0;
    dp.hasTurn = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hs_en) age++;
      else age = 0;
      dp.go      = (hs_en && age >= 2 && !hold_go) || stray_go;
      dp.hasTurn = dp.determineCurrent ? has_cur : has_opp;
    end
  end

  task automatic finalize(input logic [16:0] v, input int l);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL pulse_unexpected: got vec=%05h len=%0d, required no pulse", v, l);
    end else begin
      e = exp_q.pop_front();
      if (e.vec !== v || e.len != l) begin
        n_miss++;
        $display("FAIL pulse: got vec=%05h len=%0d, required vec=%05h len=%0d",
                 v, l, e.vec, e.len);
      end else begin
        $display("pulse vec=%05h len=%0d ok", v, l);
      end
    end
  endtask

  // Monitor: one scoreboard pop per completed enable pulse
  initial begin
    logic [16:0] prev, cur;
    int len;
    prev = '0;
    len  = 0;
    forever begin
      @(negedge clk);
      cur = en_vec;
      if (prev != 0 && cur == prev) begin
        len++;
      end else begin
        if (prev != 0) finalize(prev, len);
        if (cur != 0) len = 1;
      end
      prev = cur;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end else begin
      $display("check %s = %0h ok", name, got);
    end
  endtask

  task automatic expect_ev(input logic [16:0] v, input int l);
    ev_t e;
    e.vec = v;
    e.len = l;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input logic [4:0] k, input int hold);
    keys = k;
    tick(hold);
    keys = '0;
  endtask

  task automatic expect_new_game();
    expect_ev(E_DRAW, 2);
    expect_ev(E_INIT, 2);
    expect_ev(E_HL, 2);
  endtask

  task automatic expect_move_tail();
    expect_ev(E_CHK, 2);
    expect_ev(E_PLACE, 2);
    expect_ev(E_FLIP, 2);
    expect_ev(E_SCORE, 2);
    expect_ev(E_TURN, 2);
    expect_ev(E_DCUR, 2);
  endtask

  logic [4:0]  dir_keys [3];
  logic [16:0] dir_ens  [3];

  initial begin
    bit seen;
    dir_keys = '{K_LEFT, K_UP, K_DOWN};
    dir_ens  = '{E_ML, E_MU, E_MD};
    keys = '0; resetn = 1'b0;
    dp.validMove = 1'b0;
    has_cur = 1'b0; has_opp = 1'b0; stray_go = 1'b0; hold_go = 1'b0;

    // reset state
    tick(3);
    chk("reset_enables", 32'(en_vec), 32'h0);
    chk("reset_game_over", 32'(game_over), 32'h0);
    chk("reset_error", 32'(error), 32'h0);

    // power-up sequence
    expect_new_game();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("first_cycle_low", 32'(en_vec), 32'h0);
    tick(20);

    // held right key acts once
    expect_ev(E_MR, 1);
    expect_ev(E_HL, 2);
    press(K_RIGHT, 10);
    tick(10);

    // other directions
    for (int i = 0; i < 3; i++) begin
      expect_ev(dir_ens[i], 1);
      expect_ev(E_HL, 2);
      press(dir_keys[i], 1);
      tick(10);
    end

    // direction priority: right beats left and up
    expect_ev(E_MR, 1);
    expect_ev(E_HL, 2);
    press(K_RIGHT | K_LEFT | K_UP, 1);
    tick(10);

    // enter beats right; invalid move returns to WAIT_KEY; right press in CHECK discarded
    dp.validMove = 1'b0;
    expect_ev(E_CHK, 2);
    press(K_ENTER | K_RIGHT, 1);
    tick(1);
    press(K_RIGHT, 1);
    tick(10);

    // stray go in WAIT_KEY does nothing
    stray_go = 1'b1;
    tick(2);
    stray_go = 1'b0;
    tick(5);

    // valid move, current player keeps turn
    dp.validMove = 1'b1; has_cur = 1'b1;
    expect_move_tail();
    expect_ev(E_HL, 2);
    press(K_ENTER, 1);
    tick(40);

    // current player stuck, opponent can move -> turn handed back
    has_cur = 1'b0; has_opp = 1'b1;
    expect_move_tail();
    expect_ev(E_DOPP, 2);
    expect_ev(E_TURN, 2);
    expect_ev(E_HL, 2);
    press(K_ENTER, 1);
    tick(40);

    // nobody can move -> game over
    has_opp = 1'b0;
    expect_move_tail();
    expect_ev(E_DOPP, 2);
    expect_ev(E_RHL, 2);
    press(K_ENTER, 1);
    tick(40);
    chk("game_over_set", 32'(game_over), 32'h1);
    chk("game_over_enables", 32'(en_vec), 32'h0);

    // non-enter key and stray go ignored in GAME_OVER
    press(K_RIGHT, 1);
    stray_go = 1'b1;
    tick(2);
    stray_go = 1'b0;
    tick(3);
    chk("game_over_hold", 32'(game_over), 32'h1);

    // enter starts a new game
    expect_new_game();
    press(K_ENTER, 1);
    tick(2);
    chk("game_over_clear", 32'(game_over), 32'h0);
    tick(20);

    // reset in the middle of a highlight operation
    expect_ev(E_MR, 1);
    press(K_RIGHT, 1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (dp.moveHighlightEn) seen = 1'b1;
    end
    chk("mid_op_highlight_seen", 32'(seen), 32'h1);
    resetn = 1'b0;
    #1;
    chk("mid_op_reset_drop", 32'(en_vec), 32'h0);
    tick(2);
    expect_new_game();
    @(negedge clk);
    resetn = 1'b1;
    tick(20);

`ifdef CTRL_WATCHDOG_EN
    // withhold go in DRAW_BOARD until the watchdog trips
    hold_go = 1'b1;
    resetn = 1'b0;
    tick(2);
    expect_ev(E_DRAW, TO);
    @(negedge clk);
    resetn = 1'b1;
    tick(TO + 10);
    chk("wd_error_set", 32'(error), 32'h1);
    chk("wd_enables_low", 32'(en_vec), 32'h0);
    resetn = 1'b0;
    hold_go = 1'b0;
    tick(2);
    chk("wd_error_cleared", 32'(error), 32'h0);
    expect_new_game();
    @(negedge clk);
    resetn = 1'b1;
    tick(20);
`else
    chk("error_low", 32'(error), 32'h0);
`endif

    tick(5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
